line_mem_arbiter: RTL and testbench

- Shares the single burst physical-memory port between the instruction-side L2 cache and the data-side L2 cache.
- Arbitrates whole-line transactions.
- Serializes each 256-bit line into 64-bit beats, and deserializes incoming beats back into a line.
- Sits between the two L2 caches and the top-level mem_* ports of mp4.

---
 rtl/line_mem_arbiter_pkg.sv | 28 ++
 rtl/burst_line_buffer.sv | 56 +++++
 rtl/line_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_line_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_arbiter_pkg.sv
// rtl/line_mem_arbiter_pkg.sv - shared types and constants for the line memory arbiter
package arb_types;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int ADDR_W      = 32;
    localparam int BEATS       = LINE_W / BURST_W;
    localparam int BEAT_IDX_W  = $clog2(BEATS);
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    // Strip the byte offset so the memory always sees a line-aligned base
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// rtl/burst_line_buffer.sv - beat counter plus line register for burst serialize/deserialize
module burst_line_buffer
    import arb_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [LINE_W-1:0]     load_line,
    input  logic                  advance,
    input  logic                  store,
    input  logic [BURST_W-1:0]    beat_in,
    output logic [BEAT_IDX_W-1:0] beat_idx,
    output logic [BURST_W-1:0]    beat_out,
    output logic [LINE_W-1:0]     line_next,
    output logic                  last_beat
);

    logic [LINE_W-1:0]     line_q;
    logic [BEAT_IDX_W-1:0] cnt_q;

    // Merge the incoming beat into its slot so the completed line is visible on the final beat
    always_comb begin
        line_next = line_q;
        if (store) begin
            line_next[int'(cnt_q) * BURST_W +: BURST_W] = beat_in;
        end
    end

    assign beat_idx  = cnt_q;
    assign beat_out  = line_q[int'(cnt_q) * BURST_W +: BURST_W];
    assign last_beat = (cnt_q == BEAT_IDX_W'(BEATS - 1));

    // Line register: bulk load for write-backs, per-beat fill for reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else begin
            line_q <= line_next;
        end
    end

    // Beat counter; wraps to zero naturally after the last beat, cleared between transactions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - I/D line arbiter onto one burst memory port (option ARB_FIXED_DPRIO_EN)
module line_mem_arbiter
    import arb_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_resp,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_resp,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BURST_W-1:0] mem_wdata,
    input  logic [BURST_W-1:0] mem_rdata,
    input  logic               mem_resp
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    arb_owner_t            owner_q;
    arb_owner_t            last_grant_q;
    arb_owner_t            grant_owner;
    logic [ADDR_W-1:0]     addr_q;
    logic [LINE_W-1:0]     i_rdata_q;
    logic [LINE_W-1:0]     d_rdata_q;
    logic                  any_req;
    logic                  d_req;
    logic                  grant_d;
    logic                  buf_clear;
    logic                  buf_load;
    logic                  beat_adv;
    logic                  beat_store;
    logic                  final_read_beat;
    logic [BEAT_IDX_W-1:0] beat_idx;
    logic [BURST_W-1:0]    beat_out;
    logic [LINE_W-1:0]     line_next;
    logic                  last_beat;

    assign d_req   = d_read | d_write;
    assign any_req = i_read | d_req;

`ifdef ARB_FIXED_DPRIO_EN
    // D-side always wins a tie; I-side only gets the port when D is quiet
    assign grant_d = d_req;
`else
    // Round-robin: on a tie, the side that did not win last time goes first
    assign grant_d = d_req & (~i_read | (last_grant_q == OWN_I));
`endif

    assign grant_owner = grant_d ? OWN_D : OWN_I;

    assign beat_adv        = mem_resp & ((state_q == READ) | (state_q == WRITE));
    assign beat_store      = mem_resp & (state_q == READ);
    assign final_read_beat = beat_store & last_beat;

    // Next-state: whole-line transactions, always returning through DONE to IDLE
    always_comb begin
        state_d   = state_q;
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        case (state_q)
            IDLE: begin
                buf_clear = 1'b1;
                if (any_req) begin
                    buf_load = 1'b1;
                    // A D-side request with write set is a write-back even if read is also set
                    state_d  = (grant_d && d_write) ? WRITE : READ;
                end
            end
            READ: begin
                if (mem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (mem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; an asynchronous reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant capture: owner and line address are frozen for the whole transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            addr_q       <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            addr_q       <= line_base(grant_d ? d_address : i_address);
        end
    end

    // Returned lines are latched on the final read beat so they are valid during DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (final_read_beat) begin
            if (owner_q == OWN_I) begin
                i_rdata_q <= line_next;
            end else begin
                d_rdata_q <= line_next;
            end
        end
    end

    burst_line_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .load      (buf_load),
        .load_line (d_wdata),
        .advance   (beat_adv),
        .store     (beat_store),
        .beat_in   (mem_rdata),
        .beat_idx  (beat_idx),
        .beat_out  (beat_out),
        .line_next (line_next),
        .last_beat (last_beat)
    );

    assign mem_read    = (state_q == READ);
    assign mem_write   = (state_q == WRITE);
    assign mem_address = addr_q;
    assign mem_wdata   = (state_q == WRITE) ? beat_out : '0;
    assign i_resp      = (state_q == DONE) && (owner_q == OWN_I);
    assign d_resp      = (state_q == DONE) && (owner_q == OWN_D);
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - self-checking bench for line_mem_arbiter (honours ARB_FIXED_DPRIO_EN)
`timescale 1ns/1ps
module tb_line_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem_model [logic [31:0]];
    logic [63:0] preload   [logic [31:0]];
    logic [63:0] ref_mem   [logic [31:0]];
    logic [63:0] wbeats [$];
    int          resp_total  = 0;
    int          read_cycles = 0;
    int          gap_mode    = 0;
    logic        spurious    = 1'b0;
    int          rbeat       = 0;
    int          pidx        = 0;
    int          gap_pat [6] = '{1, 0, 1, 1, 0, 1};

    bit           last_d;
    logic [255:0] ref_i_rdata;
    logic [255:0] ref_d_rdata;

    always #5 clk = ~clk;

    line_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    function automatic logic [63:0] dflt(input logic [31:0] k);
        return {k, ~k};
    endfunction

    function automatic logic [63:0] mem_get(input logic [31:0] k);
        if (mem_model.exists(k)) return mem_model[k];
        if (preload.exists(k)) return preload[k];
        return dflt(k);
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  key;
        for (int k = 0; k < 4; k++) begin
            key = base_of(a) + 32'(k * 8);
            l[k*64 +: 64] = ref_mem.exists(key) ? ref_mem[key] : dflt(key);
        end
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [255:0] l);
        for (int k = 0; k < 4; k++) ref_mem[base_of(a) + 32'(k * 8)] = l[k*64 +: 64];
    endtask

    // Memory responder: beats in order, gaps chosen by gap_mode, optional spurious strobes when idle
    always @(negedge clk) begin
        logic        go;
        logic [31:0] key;
        if (!rst) begin
            rbeat = 0; pidx = 0; mem_resp = 1'b0; mem_rdata = '0;
        end else if (mem_read || mem_write) begin
            case (gap_mode)
                0:       go = 1'b1;
                1:       go = (gap_pat[pidx % 6] != 0);
                default: go = ($urandom_range(0, 9) < 6);
            endcase
            pidx++;
            if (mem_read) read_cycles++;
            if (go) begin
                key = mem_address + 32'(rbeat * 8);
                if (mem_read) begin
                    mem_rdata = mem_get(key);
                end else begin
                    mem_model[key] = mem_wdata;
                    wbeats.push_back(mem_wdata);
                    mem_rdata = {$urandom(), $urandom()};
                end
                rbeat++;
                resp_total++;
                mem_resp = 1'b1;
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = {$urandom(), $urandom()};
            end
        end else begin
            rbeat = 0; pidx = 0;
            mem_resp  = spurious;
            mem_rdata = {$urandom(), $urandom()};
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_cmd"}, {mem_read, mem_write, i_resp, d_resp}, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    task automatic do_single(input bit is_d, input bit wr, input bit rd_too,
                             input logic [31:0] a, input logic [255:0] wd);
        logic [255:0] exp_line;
        int           ws;
        int           rc;
        bit           ok;
        exp_line = ref_line(a);
        ws = wbeats.size();
        rc = read_cycles;
        chk("idle_before_request", {mem_read, mem_write}, 0);
        if (is_d) begin
            d_address = a; d_wdata = wd; d_write = wr; d_read = !wr || rd_too;
        end else begin
            i_address = a; i_read = 1'b1;
        end
        step();
        chk("grant_mem_address", mem_address, base_of(a));
        chk("grant_mem_cmd", {mem_read, mem_write}, (is_d && wr) ? 2'b01 : 2'b10);
        if (!is_d) i_address = $urandom();
        else d_address = $urandom();
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            step();
            if (is_d ? d_resp : i_resp) ok = 1'b1;
        end
        chk("resp_seen", ok, 1'b1);
        if (ok) begin
            chk("other_resp_quiet", is_d ? i_resp : d_resp, 1'b0);
            if (is_d && wr) begin
                ref_write(a, wd);
                chk("write_beat_count", wbeats.size() - ws, 4);
                if (wbeats.size() - ws == 4)
                    for (int k = 0; k < 4; k++) chk("write_beat", wbeats[ws + k], wd[k*64 +: 64]);
                chk("write_no_mem_read", read_cycles - rc, 0);
            end else if (is_d) begin
                ref_d_rdata = exp_line;
            end else begin
                ref_i_rdata = exp_line;
            end
            chk("i_rdata", i_rdata, ref_i_rdata);
            chk("d_rdata", d_rdata, ref_d_rdata);
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        last_d = is_d;
        step();
        chk("resp_single_cycle", {i_resp, d_resp}, 0);
    endtask

    task automatic do_both(input logic [31:0] ia, input bit dwr, input logic [31:0] da,
                           input logic [255:0] dwd, output bit got_d_first);
        bit           d_first;
        bit           got_i;
        bit           got_d;
        bit           first_set;
        logic [255:0] exp_i;
        logic [255:0] exp_d;
`ifdef ARB_FIXED_DPRIO_EN
        d_first = 1'b1;
`else
        d_first = !last_d;
`endif
        exp_d = ref_line(da);
        if (d_first && dwr) ref_write(da, dwd);
        exp_i = ref_line(ia);
        if (!d_first && dwr) ref_write(da, dwd);
        got_i = 1'b0; got_d = 1'b0; first_set = 1'b0; got_d_first = 1'b0;
        i_address = ia; i_read = 1'b1;
        d_address = da; d_wdata = dwd; d_write = dwr; d_read = !dwr;
        for (int c = 0; c < 400 && !(got_i && got_d); c++) begin
            step();
            if (i_resp && d_resp) chk("both_resp_same_cycle", 1'b1, 1'b0);
            if (d_resp) begin
                got_d = 1'b1; d_read = 1'b0; d_write = 1'b0;
                if (!first_set) begin first_set = 1'b1; got_d_first = 1'b1; end
                if (!dwr) ref_d_rdata = exp_d;
                chk("pair_d_rdata", d_rdata, ref_d_rdata);
            end
            if (i_resp) begin
                got_i = 1'b1; i_read = 1'b0;
                if (!first_set) begin first_set = 1'b1; got_d_first = 1'b0; end
                ref_i_rdata = exp_i;
                chk("pair_i_rdata", i_rdata, ref_i_rdata);
            end
        end
        chk("pair_both_done", {got_i, got_d}, 2'b11);
        chk("pair_order_d_first", got_d_first, d_first);
        last_d = !d_first;
        step();
    endtask

    logic [31:0] pool [4] = '{32'h0000_2000, 32'h0000_2020, 32'h4000_0100, 32'hFFFF_FFE0};

    initial begin
        bit           dfirst;
        logic [255:0] wd;
        int           s;
        bit           hit;
        rst = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_address = '0; d_wdata = '0;
        last_d = 1'b0; ref_i_rdata = '0; ref_d_rdata = '0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();

        // Simultaneous reads right after reset: D first, then alternation
        gap_mode = 0;
        for (int p = 0; p < 4; p++) begin
            do_both(pool[p], 1'b0, pool[3 - p] | 32'h4, '0, dfirst);
            chk("tie_d_wins_each_pair", dfirst, 1'b1);
        end

        // I-only read of a preloaded line with consecutive beats
        for (int k = 0; k < 4; k++) begin
            preload[32'h0000_1040 + 32'(k * 8)] = {16{4'(k + 1)}};
            ref_mem[32'h0000_1040 + 32'(k * 8)] = {16{4'(k + 1)}};
        end
        do_single(1'b0, 1'b0, 1'b0, 32'h0000_1040, '0);
        chk("iread_line_literal", i_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // D write-back with gaps in mem_resp
        gap_mode = 1;
        wd = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_single(1'b1, 1'b1, 1'b0, 32'h8000_00A4, wd);

        // Read and write both high: write performed, read of same line returns it
        gap_mode = 2;
        do_single(1'b1, 1'b1, 1'b1, 32'h0000_2000, rand_line());
        do_single(1'b0, 1'b0, 1'b0, 32'h0000_2008, '0);

        // Spurious strobes in IDLE must not leak into the next read
        spurious = 1'b1;
        step(); step(); step();
        spurious = 1'b0;
        do_single(1'b0, 1'b0, 1'b0, 32'h8000_00A0, '0);
        chk("read_back_writeback", i_rdata, wd);

        // Reset in the middle of a read burst
        gap_mode = 0;
        s = resp_total;
        i_address = 32'h0000_3000; i_read = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            step();
            if (resp_total - s >= 2) hit = 1'b1;
        end
        chk("midburst_reached", hit, 1'b1);
        rst = 1'b0; i_read = 1'b0;
        #1;
        chk_all_zero("midburst_reset");
        for (int c = 0; c < 3; c++) begin
            step();
            chk("reset_no_resp", {i_resp, d_resp, mem_read}, 0);
        end
        rst = 1'b1;
        last_d = 1'b0; ref_i_rdata = '0; ref_d_rdata = '0;
        step();
        gap_mode = 2;
        do_single(1'b0, 1'b0, 1'b0, 32'h0000_3000, '0);
        do_both(32'h0000_1040, 1'b0, 32'h8000_00A0, '0, dfirst);
        chk("tie_after_second_reset", dfirst, 1'b1);

        // Randomized mix against the reference model
        for (int t = 0; t < 16; t++) begin
            logic [31:0] a1;
            logic [31:0] a2;
            int          kind;
            a1 = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            a2 = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
            kind = $urandom_range(0, 4);
            case (kind)
                0: do_single(1'b0, 1'b0, 1'b0, a1, '0);
                1: do_single(1'b1, 1'b0, 1'b0, a1, '0);
                2: do_single(1'b1, 1'b1, 1'b0, a1, rand_line());
                3: do_both(a1, 1'b1, a2, rand_line(), dfirst);
                default: do_both(a1, 1'b0, a2, '0, dfirst);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
